// File: rtl/param_countdown_timer_if.sv
// Command/status bundle for param_countdown_timer: the control side drives
// commands, the timer drives count and flags back.
interface param_countdown_timer_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic [WIDTH-1:0]  in;
  logic              latch;
  logic              dec;
  logic              div;
  logic [STEP_W-1:0] step;
  logic              clr_flags;
  logic [WIDTH-1:0]  count;
  logic              zero;
  logic              tc;
  logic              underflow;
  logic [1:0]        state;

  modport master (
    output in, latch, dec, div, step, clr_flags,
    input  count, zero, tc, underflow, state
  );

  modport slave (
    input  in, latch, dec, div, step, clr_flags,
    output count, zero, tc, underflow, state
  );
endinterface

// File: rtl/param_countdown_timer.sv
// Programmable countdown timer: load / step-decrement / halve, saturating
// underflow, optional auto-reload, terminal-count pulse and exposed state.
module param_countdown_timer #(
  parameter int WIDTH       = 8,
  parameter int STEP_W      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic clk,
  input  logic reset,
  param_countdown_timer_if.slave bus
);

  // Handshake: there is no valid/ready backpressure. Every command bit is a
  // level request accepted on the rising edge where it is seen (latch > dec >
  // div, lower ones dropped); all outputs are valid in every cycle.

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    EXPIRED = 2'b10
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             underflow_q;

  logic [WIDTH-1:0] step_ext;
  logic             dec_act;
  logic             terminal;
  logic             under_evt;

  assign step_ext  = WIDTH'(bus.step);
  assign dec_act   = bus.dec && !bus.latch && (state_q == ARMED) && (bus.step != '0);
  // A step larger than the count saturates at zero instead of wrapping.
  assign terminal  = dec_act && (count_q <= step_ext);
  assign under_evt = dec_act && (count_q <  step_ext);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      reload_q    <= '0;
      tc_q        <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.latch) begin
        count_q  <= bus.in;
        reload_q <= bus.in;
        state_q  <= ARMED;
      end else if (bus.dec) begin
        if (terminal) begin
          tc_q <= 1'b1;
          // A zero reload would retrigger forever, so it expires instead.
          if (AUTO_RELOAD && (reload_q != '0)) begin
            count_q <= reload_q;
          end else begin
            count_q <= '0;
            state_q <= EXPIRED;
          end
        end else if (dec_act) begin
          count_q <= count_q - step_ext;
        end
      end else if (bus.div) begin
        count_q <= count_q >> 1;
      end

      if (under_evt) begin
        underflow_q <= 1'b1;
      end else if (bus.clr_flags) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.count     = count_q;
  assign bus.zero      = (count_q == '0);
  assign bus.tc        = tc_q;
  assign bus.underflow = underflow_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_param_countdown_timer.sv
// Bench for param_countdown_timer: three configurations driven in lockstep,
// expected responses queued by a reference model and checked by a monitor.
module tb_param_countdown_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_v = '0;
  logic        latch_v = 1'b0;
  logic        dec_v = 1'b0;
  logic        div_v = 1'b0;
  logic [3:0]  step_v = '0;
  logic        clr_v = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Entry layout per configuration: {count[15:0], zero, tc, underflow, state[1:0]}.
  logic [62:0] exp_q[$];

  // Reference model state, one slot per configuration.
  int m_count[3];
  int m_reload[3];
  int m_state[3];
  int m_tc[3];
  int m_uf[3];

  always #5 clk = ~clk;

  param_countdown_timer_if #(.WIDTH(8),  .STEP_W(4)) bus0 ();
  param_countdown_timer_if #(.WIDTH(8),  .STEP_W(4)) bus1 ();
  param_countdown_timer_if #(.WIDTH(16), .STEP_W(4)) bus2 ();

  assign bus0.in = in_v[7:0];
  assign bus1.in = in_v[7:0];
  assign bus2.in = in_v;
  assign bus0.latch = latch_v;  assign bus1.latch = latch_v;  assign bus2.latch = latch_v;
  assign bus0.dec = dec_v;      assign bus1.dec = dec_v;      assign bus2.dec = dec_v;
  assign bus0.div = div_v;      assign bus1.div = div_v;      assign bus2.div = div_v;
  assign bus0.step = step_v;    assign bus1.step = step_v;    assign bus2.step = step_v;
  assign bus0.clr_flags = clr_v; assign bus1.clr_flags = clr_v; assign bus2.clr_flags = clr_v;

  param_countdown_timer #(.WIDTH(8),  .STEP_W(4), .AUTO_RELOAD(1'b0)) u_plain8 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  param_countdown_timer #(.WIDTH(8),  .STEP_W(4), .AUTO_RELOAD(1'b1)) u_auto8 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  param_countdown_timer #(.WIDTH(16), .STEP_W(4), .AUTO_RELOAD(1'b0)) u_plain16 (
    .clk(clk), .reset(reset), .bus(bus2.slave));

  logic [20:0] act0, act1, act2;
  assign act0 = {8'h00, bus0.count, bus0.zero, bus0.tc, bus0.underflow, bus0.state};
  assign act1 = {8'h00, bus1.count, bus1.zero, bus1.tc, bus1.underflow, bus1.state};
  assign act2 = {bus2.count, bus2.zero, bus2.tc, bus2.underflow, bus2.state};

  // Behavioural rules: states 0 idle, 1 armed, 2 expired; plain integer math.
  function automatic void model_apply(int i);
    int cmax;
    int ld;
    int st;
    bit uf_evt;
    cmax   = (i == 2) ? 65535 : 255;
    ld     = int'(in_v) & cmax;
    st     = int'(step_v);
    uf_evt = 1'b0;
    m_tc[i] = 0;
    if (!reset) begin
      m_count[i] = 0; m_reload[i] = 0; m_state[i] = 0; m_uf[i] = 0;
      return;
    end
    if (latch_v) begin
      m_count[i] = ld; m_reload[i] = ld; m_state[i] = 1;
    end else if (dec_v) begin
      if (m_state[i] == 1 && st != 0) begin
        if (m_count[i] > st) begin
          m_count[i] = m_count[i] - st;
        end else begin
          m_tc[i] = 1;
          uf_evt = (m_count[i] < st);
          if (i == 1 && m_reload[i] != 0) begin
            m_count[i] = m_reload[i];
          end else begin
            m_count[i] = 0; m_state[i] = 2;
          end
        end
      end
    end else if (div_v) begin
      m_count[i] = m_count[i] / 2;
    end
    if (uf_evt) m_uf[i] = 1;
    else if (clr_v) m_uf[i] = 0;
  endfunction

  function automatic logic [20:0] model_pack(int i);
    logic [20:0] r;
    r = {16'(m_count[i]), (m_count[i] == 0), 1'(m_tc[i]), 1'(m_uf[i]), 2'(m_state[i])};
    return r;
  endfunction

  task automatic check(string name, int cyc, logic [20:0] got, logic [20:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got count=%0d zero=%0b tc=%0b uf=%0b state=%0d, expected count=%0d zero=%0b tc=%0b uf=%0b state=%0d",
               name, cyc, got[20:5], got[4], got[3], got[2], got[1:0],
               exp[20:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Driver: apply one edge's worth of inputs and queue the model's response.
  task automatic drive(bit rst, logic [15:0] d_in, bit l, bit d, bit v,
                       logic [3:0] s, bit c);
    @(negedge clk);
    reset = rst; in_v = d_in; latch_v = l; dec_v = d; div_v = v; step_v = s; clr_v = c;
    for (int i = 0; i < 3; i++) model_apply(i);
    exp_q.push_back({model_pack(2), model_pack(1), model_pack(0)});
    if (!rst) begin
      #1;
      check("async_reset_u0", -1, act0, 21'b1_0000);
      check("async_reset_u1", -1, act1, 21'b1_0000);
      check("async_reset_u2", -1, act2, 21'b1_0000);
    end
  endtask

  task automatic idle();
    drive(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // Monitor: outputs are always valid, so every edge with a queued entry is checked.
  initial begin : monitor
    logic [62:0] e;
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("plain8", cyc, act0, e[20:0]);
        check("auto8", cyc, act1, e[41:21]);
        check("plain16", cyc, act2, e[62:42]);
        cyc++;
      end
    end
  end

  initial begin : stimulus
    int r;
    logic [15:0] rin;
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle();
    drive(1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);  // dec in IDLE is ignored

    // Load then step past zero: 7,4,1 then saturating terminal with underflow.
    drive(1'b1, 16'd10, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (4) drive(1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
    idle();

    // Exact hit, then a dec in EXPIRED.
    drive(1'b1, 16'd6, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    repeat (4) drive(1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
    idle();

    // Auto-reload stream with step 1.
    drive(1'b1, 16'd3, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (9) drive(1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
    drive(1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);   // step 0 is a no-op

    // Priority: latch beats dec/div, dec beats div, then div alone.
    drive(1'b1, 16'd200, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 16'd5, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0);
    drive(1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
    repeat (3) drive(1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);

    // Reset mid-run, then dec after release is ignored.
    drive(1'b1, 16'd77, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
    drive(1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);

    // Underflow flag: set, clear, then set wins over a same-edge clear.
    drive(1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0);
    drive(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    drive(1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 4'd15, 1'b1);
    idle();

    // Latched zero while ARMED counts as an underflowing terminal decrement.
    drive(1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    drive(1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);

    // Randomized mix biased toward decrements and small loads.
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 99);
      rin = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      drive((r >= 2),
            rin,
            ($urandom_range(0, 99) < 12),
            ($urandom_range(0, 99) < 60),
            ($urandom_range(0, 99) < 20),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 10));
    end
    idle();

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_countdown_timer.md
Name: param_countdown_timer

Overview:
- WIDTH-parametrised load/decrement/halve countdown counter; next generation of the team's 8-bit load/dec/div counter.
- Adds:
  - programmable decrement step
  - saturating underflow with a sticky flag
  - optional auto-reload from the last latched value
  - one-cycle terminal-count pulse
  - explicit IDLE/ARMED/EXPIRED state machine
- Sits between a control register block and downstream event logic as a reusable programmable timer.

Parameters:
- WIDTH, 8, counter and load-value width (>=2).
- STEP_W, 4, width of the per-cycle decrement step input (1..WIDTH).
- AUTO_RELOAD, 0, 1 = reaching zero by decrement reloads the last latched value and stays ARMED; 0 = stops in EXPIRED.

Ports:
- clk, input, 1, single clock, all state updates on rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
- in, input, WIDTH, load value.
- latch, input, 1, load in into count and reload register.
- dec, input, 1, decrement count by step.
- div, input, 1, halve count (logical shift right by 1).
- step, input, STEP_W, decrement amount; 0 = no-op.
- clr_flags, input, 1, clears underflow.
- count, output, WIDTH, current count value.
- zero, output, 1, combinational (count == 0), no latency.
- tc, output, 1, registered one-cycle terminal-count pulse.
- underflow, output, 1, sticky: a decrement requested more than count held.
- state, output, 2, 00 IDLE, 01 ARMED, 10 EXPIRED (11 unused).

Behaviour:
- Reset (reset=0, async): count=0, reload register=0, tc=0, underflow=0, state=IDLE, hence zero=1. Outputs hold until the first rising edge with reset=1. Reset mid-operation aborts immediately; nothing is retained.
- Command priority per edge: latch > dec > div. Only the highest-priority asserted command acts; lower ones are dropped, not queued.
- latch (any state):
  - count<=in, reload<=in, tc<=0.
  - state<=ARMED, even if in==0.
- dec, acting only in ARMED. In IDLE/EXPIRED, dec is ignored (count unchanged, no flags).
  - step==0: no change.
  - count > step: count<=count-step.
  - count == step:
    - count<=0, tc<=1 for exactly one cycle.
    - If AUTO_RELOAD=1 and reload != 0: count<=reload, state stays ARMED. Otherwise state<=EXPIRED.
  - count < step: identical to the count == step case, plus underflow<=1. Arithmetic never wraps.
  - count==0 while ARMED (latched 0): treated as count < step when step != 0.
  - AUTO_RELOAD=1 with reload==0: goes to EXPIRED; no self-retriggering loop.
- div (any state):
  - count<=count>>1 (floor); count 1 becomes 0.
  - No tc, no state change, no underflow, even if the result is 0.
- tc: high only in the cycle following the terminal edge; deasserts on the next edge unless a new terminal event occurs. Back-to-back auto-reload events with reload <= step give tc high every cycle.
- underflow: cleared only by clr_flags or reset. If clr_flags and a new underflow event share an edge, set wins.
- No input is registered; command-to-count latency is 1 clock.
- state transitions:
  - IDLE -> ARMED on latch.
  - ARMED -> EXPIRED on a terminal decrement (non-reload case).
  - EXPIRED -> ARMED on latch.
  - No other transitions except reset.

Test Plan:
- Reset and load: release reset, latch in=8'd10 -> count=10, state=ARMED, zero=0. Then dec with step=3 for 3 edges -> count 7,4,1; 4th dec -> count=0, tc=1 one cycle, underflow=1, state=EXPIRED.
- Exact hit, no underflow: latch 8'd6, dec step=2 x3 -> count 4,2,0; tc pulses once after the 3rd edge, underflow stays 0. A further dec is ignored: count stays 0, tc=0.
- Auto-reload (AUTO_RELOAD=1): latch 8'd3, dec step=1 x3 -> count 2,1,3, tc pulse on the reload edge, state stays ARMED. 6 further decs -> tc pulses exactly twice more.
- Priority and div: count=8'd200, assert latch(in=5)+dec+div on one edge -> count=5. Then dec+div together -> count=4. Then div alone -> count=2, then 1, then 0, with tc never asserted.
- Async reset mid-run: count=8'd77 ARMED, pull reset low between edges -> count=0, zero=1, state=IDLE before the next edge. dec after release -> ignored.
- Flags and width: with WIDTH=16, latch 16'd1, dec step=15 -> underflow=1. Assert clr_flags alone -> underflow=0. Repeat with clr_flags on the same edge as an underflow event -> underflow=1.
